// File: rtl/serial_tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// serial_tx_arb_pkg
// Shared definitions for the serial transmit arbiter: the arbiter state
// encoding and the default sizing of the requester array and stall timeout.
// No ports (package).
// ---------------------------------------------------------------------------
package serial_tx_arb_pkg;

    // IDLE: no owner. SEND: owner granted, waiting to hand a byte to the UART.
    // GAP: one cycle after each byte, so tx_start is never high twice in a row.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int NREQ_DEFAULT    = 2;
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// (last_grant + 1) mod NREQ, wrapping around, and returns a one-hot grant
// for the first requester found (all-zero when nothing is requesting).
//
// Ports
//   req        in   NREQ       request vector
//   last_grant in   clog2      index of the previously served requester
//   grant      out  NREQ       one-hot winner
// ---------------------------------------------------------------------------
module rr_pick
    import serial_tx_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         grant
);

    localparam int IW = $clog2(NREQ);

    // cand_idx[k] is the requester examined at search position k.
    logic [IW-1:0] cand_idx [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = IW'((int'(last_grant) + gi + 1) % NREQ);
        end
    endgenerate

    // Walk from the farthest position back to the nearest, so the nearest
    // active requester is the one that ends up owning the grant.
    always_comb begin
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                grant              = '0;
                grant[cand_idx[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter
// Shares one UART transmitter between NREQ byte-stream requesters. Packets
// are atomic: once a requester is granted it keeps the transmitter until the
// byte flagged req_last has been consumed. Owners rotate round-robin.
// Each byte costs at least two cycles (SEND then GAP).
//
// Optional feature: define SERIAL_TX_ARB_TIMEOUT_EN to add a stall timer that
// releases a grant whose owner leaves req_valid low for TIMEOUT SEND cycles
// mid-packet, counting such drops in drop_count. Without it drop_count is 0.
//
// Ports
//   clk         in   1       clock
//   rst_n       in   1       synchronous active-low reset
//   req_valid   in   NREQ    requester i has a byte on req_data
//   req_data    in   NREQ*8  byte of requester i at [i*8 +: 8]
//   req_last    in   NREQ    byte of requester i ends its packet
//   req_ready   out  NREQ    one-cycle pulse: byte of requester i consumed
//   grant       out  NREQ    one-hot current owner, zero when idle
//   tx_busy     in   1       UART busy
//   tx_start    out  1       one-cycle start pulse to the UART
//   tx_data     out  8       byte to the UART, valid with tx_start
//   drop_count  out  8       saturating count of timed-out packets
// ---------------------------------------------------------------------------
module serial_tx_arbiter
    import serial_tx_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [7:0]        drop_count
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [IW-1:0]   last_grant_reg, last_grant_next;
    logic            last_flag_reg, last_flag_next;
    logic            tx_start_reg, tx_start_next;
    logic [7:0]      tx_data_reg, tx_data_next;
    logic [NREQ-1:0] req_ready_reg, req_ready_next;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   grant_idx;
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic [7:0]      masked_data [NREQ];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (pick_grant)
    );

    // AND-OR mux of the owner's byte; grant_reg is one-hot so at most one
    // lane contributes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign masked_data[gi] = req_data[gi*8 +: 8] & {8{grant_reg[gi]}};
        end
    endgenerate

    assign sel_valid = |(req_valid & grant_reg);
    assign sel_last  = |(req_last & grant_reg);

    always_comb begin
        sel_data  = '0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_data = sel_data | masked_data[i];
            if (grant_reg[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    logic [7:0] stall_cnt_reg, stall_cnt_next;
    logic [7:0] drop_cnt_reg, drop_cnt_next;
    logic       stall_expired;

    // True on the stall cycle that brings the counter up to TIMEOUT.
    assign stall_expired = ({1'b0, stall_cnt_reg} + 9'd1) >= 9'(TIMEOUT);
`endif

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        last_flag_next  = last_flag_reg;
        tx_start_next   = 1'b0;
        tx_data_next    = tx_data_reg;
        req_ready_next  = '0;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
        stall_cnt_next  = stall_cnt_reg;
        drop_cnt_next   = drop_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    grant_next = pick_grant;
                    state_next = SEND;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
                    stall_cnt_next = '0;
`endif
                end
            end
            SEND: begin
                if (sel_valid && !tx_busy) begin
                    tx_data_next   = sel_data;
                    tx_start_next  = 1'b1;
                    req_ready_next = grant_reg;
                    last_flag_next = sel_last;
                    state_next     = GAP;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
                    stall_cnt_next = '0;
`endif
                end
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
                else if (!sel_valid) begin
                    if (stall_expired) begin
                        grant_next      = '0;
                        last_grant_next = grant_idx;
                        state_next      = IDLE;
                        stall_cnt_next  = '0;
                        if (drop_cnt_reg != 8'hFF) begin
                            drop_cnt_next = drop_cnt_reg + 8'd1;
                        end
                    end else begin
                        stall_cnt_next = stall_cnt_reg + 8'd1;
                    end
                end
`endif
            end
            GAP: begin
                if (last_flag_reg) begin
                    grant_next      = '0;
                    last_grant_next = grant_idx;
                    state_next      = IDLE;
                end else begin
                    state_next = SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // last_grant resets to NREQ-1 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IW'(NREQ - 1);
            last_flag_reg  <= 1'b0;
            tx_start_reg   <= 1'b0;
            tx_data_reg    <= '0;
            req_ready_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            last_flag_reg  <= last_flag_next;
            tx_start_reg   <= tx_start_next;
            tx_data_reg    <= tx_data_next;
            req_ready_reg  <= req_ready_next;
        end
    end

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    assign drop_count = drop_cnt_reg;
`else
    // No stall timer in this build; the mask keeps TIMEOUT referenced while
    // the output stays at zero.
    assign drop_count = 8'(TIMEOUT) & 8'h00;
`endif

    assign grant     = grant_reg;
    assign req_ready = req_ready_reg;
    assign tx_start  = tx_start_reg;
    assign tx_data   = tx_data_reg;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
module tb_serial_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_busy;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [7:0]     drop_count;

    always #5 clk = ~clk;

    serial_tx_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .drop_count (drop_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Requester model: per-requester byte queues {last, data}.
    logic [8:0] mem [N][64];
    int         head [N];
    int         tail [N];
    int         hold_cnt [N];

    // Scoreboard state: owner of the packet in flight, previous owner.
    int  cur_owner;
    int  last_owner;
    int  last_start;
    bit  sb_en;
    bit  rand_busy;
    bit  rand_hold;
    logic busy_at_edge;
    logic rst_at_edge;

    int         log_owner [64];
    int         log_cyc [64];
    logic [7:0] log_data [64];
    int         nlog;
    int         load_cyc;
    int         n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mem[i][tail[i]] = {l, d};
        tail[i]++;
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += tail[i] - head[i];
        return s;
    endfunction

    // Next owner: first requester with queued bytes after the previous owner.
    function automatic int rr_next();
        for (int k = 1; k <= N; k++) begin
            if (head[(last_owner + k) % N] < tail[(last_owner + k) % N])
                return (last_owner + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        if (!sb_en) return;
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i] && hold_cnt[i] == 0) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = mem[i][head[i]][7:0];
                req_last[i]         = mem[i][head[i]][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
    endtask

    task automatic observe();
        int   o;
        logic lst;
        o = cur_owner;
        if (tx_start) begin
            if (o < 0) o = rr_next();
            check("start_while_busy", {31'd0, busy_at_edge}, 0);
            if (last_start >= 0) check("start_spacing", {31'd0, (cyc - last_start) >= 2}, 1);
            last_start = cyc;
            if (o < 0) begin
                check("spurious_start", {31'd0, tx_start}, 0);
            end else begin
                check("start_grant", {29'd0, grant}, 32'(1) << o);
                check("start_ready", {29'd0, req_ready}, 32'(1) << o);
                check("start_data", {24'd0, tx_data}, {24'd0, mem[o][head[o]][7:0]});
                log_owner[nlog] = o;
                log_cyc[nlog]   = cyc;
                log_data[nlog]  = tx_data;
                nlog++;
                lst = mem[o][head[o]][8];
                head[o]++;
                if (lst) begin
                    last_owner = o;
                    cur_owner  = -1;
                end else begin
                    cur_owner   = o;
                    hold_cnt[o] = rand_hold ? int'($urandom_range(0, 2)) : 0;
                end
            end
        end else begin
            check("ready_without_start", {29'd0, req_ready}, 0);
            if (o >= 0) check("atomic_grant", {29'd0, grant}, 32'(1) << o);
        end
    endtask

    task automatic tick();
        drive_inputs();
        busy_at_edge = tx_busy;
        rst_at_edge  = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (hold_cnt[i] > 0) hold_cnt[i]--;
        if (rst_at_edge && sb_en) observe();
    endtask

    task automatic run_drain(input string tag, input int budget);
        int k = 0;
        while ((pending() > 0 || cur_owner >= 0) && k < budget) begin
            tx_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            k++;
        end
        check({tag, "_drained"}, pending(), 0);
        tx_busy = 1'b0;
        tick();
        tick();
        check({tag, "_grant_idle"}, {29'd0, grant}, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; hold_cnt[i] = 0;
        end
        cur_owner  = -1;
        last_owner = N - 1;
        last_start = -1;
        rst_n   = 1'b0;
        tx_busy = 1'b0;
        tick();
        check("rst_grant", {29'd0, grant}, 0);
        check("rst_ready", {29'd0, req_ready}, 0);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_drop_count", {24'd0, drop_count}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        sb_en = 1'b1; rand_busy = 1'b0; rand_hold = 1'b0; nlog = 0;
        do_reset();

        // Single 3-byte packet from requester 0.
        nlog = 0; load_cyc = cyc;
        push(0, 8'h04, 1'b0); push(0, 8'h10, 1'b0); push(0, 8'hAA, 1'b1);
        run_drain("single", 100);
        check("single_count", nlog, 3);
        check("single_b0", {24'd0, log_data[0]}, 32'h04);
        check("single_b1", {24'd0, log_data[1]}, 32'h10);
        check("single_b2", {24'd0, log_data[2]}, 32'hAA);
        check("single_latency", log_cyc[0] - load_cyc, 2);
        check("single_gap01", log_cyc[1] - log_cyc[0], 2);
        check("single_gap12", log_cyc[2] - log_cyc[1], 2);
        $display("[TB] single packet: %0d bytes", nlog);

        // Contention: req0 and req1 2-byte packets from the same cycle.
        do_reset();
        nlog = 0;
        push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
        push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b1);
        run_drain("cont", 100);
        check("cont_count", nlog, 4);
        for (int k = 0; k < 4; k++) begin
            check("cont_owner", log_owner[k], k / 2);
            check("cont_data", {24'd0, log_data[k]}, 32'h11 + 32'(16 * (k / 2) + (k % 2)));
        end
        $display("[TB] contention: %0d bytes", nlog);

        // Fairness: single-byte packets on req0 and req1.
        nlog = 0;
        for (int k = 0; k < 4; k++) begin
            push(0, 8'(8'h30 + k), 1'b1);
            push(1, 8'(8'h40 + k), 1'b1);
        end
        run_drain("fair", 200);
        check("fair_count", nlog, 8);
        for (int k = 0; k < 8; k++) check("fair_owner", log_owner[k], k % 2);
        $display("[TB] fairness: %0d grants", nlog);

        // Busy stall on requester 2.
        nlog = 0;
        tx_busy = 1'b1;
        push(2, 8'h5A, 1'b1);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("busy_no_start", {31'd0, tx_start}, 0);
            check("busy_no_ready", {29'd0, req_ready}, 0);
        end
        tx_busy = 1'b0;
        tick();
        check("busy_release_start", {31'd0, tx_start}, 1);
        check("busy_release_data", {24'd0, tx_data}, 32'h5A);
        check("busy_release_grant", {29'd0, grant}, 32'b100);
        run_drain("busy", 20);
        $display("[TB] busy stall: byte sent after release");

        // Wrap: last owner was requester 2, so requester 0 goes first.
        nlog = 0;
        push(1, 8'h61, 1'b1); push(0, 8'h60, 1'b1);
        run_drain("wrap", 100);
        check("wrap_first", log_owner[0], 0);
        check("wrap_second", log_owner[1], 1);
        $display("[TB] wrap: order %0d,%0d", log_owner[0], log_owner[1]);

        // Randomised traffic with random busy and mid-packet valid gaps.
        rand_busy = 1'b1; rand_hold = 1'b1;
        for (int r = 0; r < 6; r++) begin
            nlog = 0;
            for (int i = 0; i < N; i++) begin
                head[i] = 0; tail[i] = 0;
                for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            run_drain("rand", 3000);
            $display("[TB] random round %0d: %0d bytes", r, nlog);
        end
        rand_busy = 1'b0; rand_hold = 1'b0;

        // Reset in the middle of a 5-byte packet, then a fresh req1 packet.
        do_reset();
        nlog = 0;
        for (int b = 0; b < 5; b++) push(0, 8'(8'h81 + b), b == 4);
        n = 0;
        while (head[0] < 2 && n < 50) begin tick(); n++; end
        check("rstmid_progress", head[0], 2);
        do_reset();
        nlog = 0;
        push(1, 8'h99, 1'b1);
        run_drain("rstmid", 100);
        check("rstmid_count", nlog, 1);
        check("rstmid_owner", log_owner[0], 1);
        check("rstmid_data", {24'd0, log_data[0]}, 32'h99);
        $display("[TB] reset mid-packet: next owner %0d", log_owner[0]);

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
        // Stall timeout: req0 sends one non-last byte then drops valid.
        do_reset();
        sb_en = 1'b0;
        req_valid = 3'b011;
        req_data  = {8'h00, 8'h66, 8'h55};
        req_last  = 3'b010;
        n = 0;
        while (!tx_start && n < 20) begin tick(); n++; end
        check("to_first_start", {31'd0, tx_start}, 1);
        check("to_first_data", {24'd0, tx_data}, 32'h55);
        check("to_first_grant", {29'd0, grant}, 32'b001);
        req_valid[0] = 1'b0;
        n = 0;
        while (grant != '0 && n < 20) begin tick(); n++; end
        check("to_release_cycles", n, TO + 1);
        check("to_drop_count", {24'd0, drop_count}, 1);
        n = 0;
        while (!tx_start && n < 20) begin tick(); n++; end
        check("to_next_start", {31'd0, tx_start}, 1);
        check("to_next_data", {24'd0, tx_data}, 32'h66);
        check("to_next_grant", {29'd0, grant}, 32'b010);
        req_valid = '0;
        tick(); tick();
        sb_en = 1'b1;
        $display("[TB] timeout: drop_count %0d", drop_count);
`else
        check("drop_count_tied", {24'd0, drop_count}, 0);
        $display("[TB] drop_count stays %0d", drop_count);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
